// File: rtl/vreg_sequencer.sv
// Walks the vs1/vs2/vd register groups of one vector instruction, 4 elements per beat,
// and retires each beat PE_LATENCY cycles later. Define VREG_SEQ_CHECK_EN for start-time legality checks.
module vreg_sequencer #(
    parameter int PE_LATENCY = 2,
    parameter int VL_W       = 6
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            start,
    output logic            ready,
    input  logic [4:0]      vs1_base,
    input  logic [4:0]      vs2_base,
    input  logic [4:0]      vd_base,
    input  logic [VL_W-1:0] vl,
    input  logic [1:0]      sew_in,
    input  logic            widen_in,
    input  logic            uses_vs3,
    output logic [4:0]      vs1_addr,
    output logic [4:0]      vs2_addr,
    output logic [4:0]      vd_addr,
    output logic [1:0]      vsew,
    output logic            widening_op,
    output logic            write,
    output logic [1:0]      elements_to_write,
    output logic            pe_valid,
    output logic            done,
    output logic            err
);
    // state   | meaning
    // S_IDLE  | ready for a new instruction
    // S_ISSUE | beats still to issue (one per cycle unless bubbled)
    // S_DRAIN | all beats issued, waiting for the write-back pipe to empty
    // S_DONE  | done pulse, back to idle next cycle
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam int BW = VL_W - 1;

    state_t          state;
    logic [BW-1:0]   left;
    logic [1:0]      rem_q;
    logic [4:0]      str_r, str_d;
    logic            vs3_q;
    logic [4:0]      p_vs1, p_vs2, p_vd;
    logic [4:0]      beat_vd;
    logic [1:0]      beat_etw;
    logic [PE_LATENCY-1:0] pv;
    logic [4:0]      pa [PE_LATENCY];
    logic [1:0]      pe [PE_LATENCY];

    logic [VL_W:0]   vl_p3;
    logic [BW-1:0]   in_beats;
    logic [4:0]      in_str_r, in_str_d;
    logic            accept, chk_err, issue_go, bubble, pending;
    logic            nxt_wv;
    logic [4:0]      nxt_wa;
    logic [4:0]      src_vs1, src_vs2, src_vd, src_str_r, src_str_d;
    logic [BW-1:0]   src_left;
    logic [1:0]      src_rem, src_etw;
    logic            src_last;

    assign vl_p3    = {1'b0, vl} + (VL_W+1)'(3);
    assign in_beats = vl_p3[VL_W:2];
    assign in_str_r = 5'd1 << sew_in;
    assign in_str_d = widen_in ? (in_str_r << 1) : in_str_r;
    assign accept   = (state == S_IDLE) && start;

    assign write             = pv[PE_LATENCY-1];
    assign elements_to_write = pe[PE_LATENCY-1];

    // The write that will retire next cycle decides bubbling and vd_addr ownership.
    generate
        if (PE_LATENCY == 1) begin : g_lat1
            assign nxt_wv  = pe_valid;
            assign nxt_wa  = beat_vd;
            assign pending = pe_valid;
        end else begin : g_latn
            assign nxt_wv  = pv[PE_LATENCY-2];
            assign nxt_wa  = pa[PE_LATENCY-2];
            assign pending = pe_valid | (|pv[PE_LATENCY-2:0]);
        end
    endgenerate

`ifdef VREG_SEQ_CHECK_EN
    function automatic logic [8:0] ceil_pow2(input logic [8:0] g);
        logic [8:0] p;
        p = 9'd1;
        for (int i = 0; i < 8; i++) if (p < g) p = p << 1;
        return p;
    endfunction

    logic [8:0] grp_r, grp_d;
    logic [4:0] msk_r, msk_d;
    always_comb begin
        grp_r   = ceil_pow2(9'(in_beats) * 9'(in_str_r));
        grp_d   = ceil_pow2(9'(in_beats) * 9'(in_str_d));
        msk_r   = (grp_r >= 9'd32) ? 5'h1f : 5'(grp_r - 9'd1);
        msk_d   = (grp_d >= 9'd32) ? 5'h1f : 5'(grp_d - 9'd1);
        chk_err = (vd_base == 5'd0) || (widen_in && sew_in == 2'd2)
               || ((vs1_base & msk_r) != 5'd0) || ((vs2_base & msk_r) != 5'd0)
               || ((vd_base & msk_d) != 5'd0)
               || (grp_r > 9'd32) || (grp_d > 9'd32);
    end
`else
    assign chk_err = 1'b0;
`endif

    always_comb begin
        if (state == S_IDLE) begin
            src_vs1   = vs1_base;
            src_vs2   = vs2_base;
            src_vd    = vd_base;
            src_str_r = in_str_r;
            src_str_d = in_str_d;
            src_left  = in_beats;
            src_rem   = vl[1:0];
        end else begin
            src_vs1   = p_vs1;
            src_vs2   = p_vs2;
            src_vd    = p_vd;
            src_str_r = str_r;
            src_str_d = str_d;
            src_left  = left;
            src_rem   = rem_q;
        end
        src_last = (src_left == BW'(1));
        src_etw  = (src_last && src_rem != 2'd0) ? src_rem : 2'd0;
        bubble   = vs3_q && nxt_wv;
        issue_go = ((state == S_ISSUE) && !bubble)
                || (accept && (vl != '0) && !chk_err);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            pe_valid    <= 1'b0;
            vs1_addr    <= '0;
            vs2_addr    <= '0;
            vd_addr     <= '0;
            vsew        <= '0;
            widening_op <= 1'b0;
            left        <= '0;
            rem_q       <= '0;
            str_r       <= '0;
            str_d       <= '0;
            vs3_q       <= 1'b0;
            p_vs1       <= '0;
            p_vs2       <= '0;
            p_vd        <= '0;
            beat_vd     <= '0;
            beat_etw    <= '0;
            pv          <= '0;
            for (int i = 0; i < PE_LATENCY; i++) begin
                pa[i] <= '0;
                pe[i] <= '0;
            end
        end else begin
            err  <= 1'b0;
            done <= 1'b0;

            pv[0] <= pe_valid;
            pa[0] <= beat_vd;
            pe[0] <= beat_etw;
            for (int i = 1; i < PE_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pe[i] <= pe[i-1];
            end

            pe_valid <= issue_go;
            vd_addr  <= nxt_wv ? nxt_wa : (issue_go ? src_vd : 5'd0);
            if (issue_go) begin
                vs1_addr <= src_vs1;
                vs2_addr <= src_vs2;
                beat_vd  <= src_vd;
                beat_etw <= src_etw;
                p_vs1    <= src_vs1 + src_str_r;
                p_vs2    <= src_vs2 + src_str_r;
                p_vd     <= src_vd + src_str_d;
                left     <= src_left - BW'(1);
            end else begin
                vs1_addr <= '0;
                vs2_addr <= '0;
                beat_vd  <= '0;
                beat_etw <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (chk_err) begin
                            err <= 1'b1;
                        end else begin
                            vsew        <= sew_in;
                            widening_op <= widen_in;
                            vs3_q       <= uses_vs3;
                            str_r       <= in_str_r;
                            str_d       <= in_str_d;
                            rem_q       <= vl[1:0];
                            ready       <= 1'b0;
                            if (vl == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= src_last ? S_DRAIN : S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_go && src_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!pending) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vreg_sequencer.sv
// Directed bench for vreg_sequencer (PE_LATENCY=2, VL_W=6): per-cycle expected
// outputs are hand-derived for each instruction.
module tb_vreg_sequencer;
    logic       clk, n_reset, start, ready;
    logic [4:0] vs1_base, vs2_base, vd_base;
    logic [5:0] vl;
    logic [1:0] sew_in, vsew, elements_to_write;
    logic       widen_in, uses_vs3, widening_op, write, pe_valid, done, err;
    logic [4:0] vs1_addr, vs2_addr, vd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    vreg_sequencer #(.PE_LATENCY(2), .VL_W(6)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .ready(ready),
        .vs1_base(vs1_base), .vs2_base(vs2_base), .vd_base(vd_base), .vl(vl),
        .sew_in(sew_in), .widen_in(widen_in), .uses_vs3(uses_vs3),
        .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vd_addr(vd_addr),
        .vsew(vsew), .widening_op(widening_op), .write(write),
        .elements_to_write(elements_to_write), .pe_valid(pe_valid),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd,
                         input logic [5:0] l, input logic [1:0] s, input logic w, input logic v3);
        @(negedge clk);
        vs1_base = b1; vs2_base = b2; vd_base = bd; vl = l;
        sew_in = s; widen_in = w; uses_vs3 = v3; start = 1'b1;
        check("ready_at_start", ready, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic e_pv, input logic [4:0] e_vs1,
                       input logic [4:0] e_vs2, input logic [4:0] e_vd, input logic e_wr,
                       input logic [1:0] e_etw, input logic e_done, input logic e_rdy);
        @(negedge clk);
        check({tag, ".pe_valid"}, pe_valid, e_pv);
        if (e_pv) begin
            check({tag, ".vs1_addr"}, vs1_addr, e_vs1);
            check({tag, ".vs2_addr"}, vs2_addr, e_vs2);
        end
        if (e_pv || e_wr) check({tag, ".vd_addr"}, vd_addr, e_vd);
        check({tag, ".write"}, write, e_wr);
        if (e_wr) check({tag, ".etw"}, elements_to_write, e_etw);
        check({tag, ".done"}, done, e_done);
        check({tag, ".ready"}, ready, e_rdy);
        check({tag, ".err"}, err, 1'b0);
    endtask

    initial begin
        clk = 0; n_reset = 0; start = 0;
        vs1_base = 0; vs2_base = 0; vd_base = 0; vl = 0;
        sew_in = 0; widen_in = 0; uses_vs3 = 0;
        #12;
        check("rst.ready", ready, 1'b1);
        check("rst.pe_valid", pe_valid, 1'b0);
        check("rst.write", write, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.vd_addr", vd_addr, 5'd0);
        check("rst.err", err, 1'b0);
        @(negedge clk) n_reset = 1'b1;

        // single beat; a start pulse mid-instruction must be ignored
        issue(5'd2, 5'd4, 5'd6, 6'd4, 2'd0, 1'b0, 1'b0);
        cyc("t1.c1", 1, 5'd2, 5'd4, 5'd6, 0, 2'd0, 0, 0);
        start = 1'b1; sew_in = 2'd2; vl = 6'd8;
        cyc("t1.c2", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 0);
        start = 1'b0;
        cyc("t1.c3", 0, 5'd0, 5'd0, 5'd6, 1, 2'd0, 0, 0);
        check("t1.vsew", vsew, 2'd0);
        cyc("t1.c4", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 1, 0);
        cyc("t1.c5", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 1);

        // 32b, vl=10: three beats, partial last, write priority on vd_addr, 5-bit wrap on vs2
        issue(5'd0, 5'd24, 5'd8, 6'd10, 2'd2, 1'b0, 1'b0);
        cyc("t2.c1", 1, 5'd0, 5'd24, 5'd8,  0, 2'd0, 0, 0);
        check("t2.vsew", vsew, 2'd2);
        cyc("t2.c2", 1, 5'd4, 5'd28, 5'd12, 0, 2'd0, 0, 0);
        cyc("t2.c3", 1, 5'd8, 5'd0,  5'd8,  1, 2'd0, 0, 0);
        cyc("t2.c4", 0, 5'd0, 5'd0,  5'd12, 1, 2'd0, 0, 0);
        cyc("t2.c5", 0, 5'd0, 5'd0,  5'd16, 1, 2'd2, 0, 0);
        cyc("t2.c6", 0, 5'd0, 5'd0,  5'd0,  0, 2'd0, 1, 0);
        cyc("t2.c7", 0, 5'd0, 5'd0,  5'd0,  0, 2'd0, 0, 1);

        // widening 16b with vs3: vd stride 4, beats bubbled while writes retire
        issue(5'd2, 5'd10, 5'd4, 6'd16, 2'd1, 1'b1, 1'b1);
        cyc("t3.c1", 1, 5'd2, 5'd10, 5'd4,  0, 2'd0, 0, 0);
        check("t3.widening_op", widening_op, 1'b1);
        cyc("t3.c2", 1, 5'd4, 5'd12, 5'd8,  0, 2'd0, 0, 0);
        cyc("t3.c3", 0, 5'd0, 5'd0,  5'd4,  1, 2'd0, 0, 0);
        cyc("t3.c4", 0, 5'd0, 5'd0,  5'd8,  1, 2'd0, 0, 0);
        cyc("t3.c5", 1, 5'd6, 5'd14, 5'd12, 0, 2'd0, 0, 0);
        cyc("t3.c6", 1, 5'd8, 5'd16, 5'd16, 0, 2'd0, 0, 0);
        cyc("t3.c7", 0, 5'd0, 5'd0,  5'd12, 1, 2'd0, 0, 0);
        cyc("t3.c8", 0, 5'd0, 5'd0,  5'd16, 1, 2'd0, 0, 0);
        cyc("t3.c9", 0, 5'd0, 5'd0,  5'd0,  0, 2'd0, 1, 0);
        cyc("t3.c10", 0, 5'd0, 5'd0, 5'd0,  0, 2'd0, 0, 1);

        // vl=0: no beats, done right after acceptance
        issue(5'd1, 5'd2, 5'd3, 6'd0, 2'd0, 1'b0, 1'b0);
        cyc("t4.c1", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 1, 0);
        cyc("t4.c2", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 1);
        cyc("t4.c3", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 1);

        // reset while a write is still in the pipe
        issue(5'd2, 5'd4, 5'd6, 6'd3, 2'd0, 1'b0, 1'b0);
        cyc("t5.c1", 1, 5'd2, 5'd4, 5'd6, 0, 2'd0, 0, 0);
        cyc("t5.c2", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 0);
        n_reset = 1'b0;
        #1;
        check("t5.rst.write", write, 1'b0);
        check("t5.rst.pe_valid", pe_valid, 1'b0);
        check("t5.rst.vd_addr", vd_addr, 5'd0);
        check("t5.rst.done", done, 1'b0);
        check("t5.rst.ready", ready, 1'b1);
        @(negedge clk);
        check("t5.rst.write_hold", write, 1'b0);
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc("t5.after", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 1);

`ifdef VREG_SEQ_CHECK_EN
        issue(5'd0, 5'd0, 5'd6, 6'd8, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        check("t6.err", err, 1'b1);
        check("t6.ready", ready, 1'b1);
        check("t6.write", write, 1'b0);
        check("t6.pe_valid", pe_valid, 1'b0);
        for (int i = 0; i < 4; i++) cyc("t6.after", 0, 5'd0, 5'd0, 5'd0, 0, 2'd0, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
